onehot_capture_enc: RTL and testbench
=====================================

Name: onehot_capture_enc

Overview:
Registered downstream stage for the 3-to-8 address decoder. It accepts the decoder's 8-bit one-hot word Y over a valid/ready handshake and re-encodes it to a 3-bit index held in a one-entry output register. It checks one-hot legality and flags a word identical to the previously accepted one, which exposes a decoder output held stale by a missing decode branch. Errors are counted for test and debug.

Parameters:
WIDTH, 8, one-hot input width; legal values are powers of two from 2 to 256.
AW, 3, index width; must equal log2(WIDTH), checked at elaboration.
CNT_W, 8, error-counter width.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous active-high reset.
in_valid  input  1  upstream word valid.
in_ready  output  1  stage can accept a word this cycle.
in_onehot  input  WIDTH  decoder output Y.
out_valid  output  1  output register holds a word.
out_ready  input  1  downstream accepts the word.
out_addr  output  AW  encoded index.
out_err  output  1  word held in the register was not one-hot.
out_same  output  1  word held in the register equalled the previous accepted word.
clear_err  input  1  synchronous clear of err_count and err_sticky.
err_count  output  CNT_W  saturating count of accepted non-one-hot words.
err_sticky  output  1  set on any accepted error; held until cleared.

Behaviour:
- Reset state, applied asynchronously: out_valid=0, out_addr=0, out_err=0, out_same=0, err_count=0, err_sticky=0, prev_word=0, prev_vld=0.
- Storage is a single output register with two implicit states, EMPTY (out_valid=0) and FULL (out_valid=1).
- in_ready = !out_valid || out_ready. This is combinational, so a full pipeline runs at 1 word per cycle.
- Accept condition: in_valid && in_ready. Latency from an accepted word to out_valid=1 is 1 clock.
- Drain condition: out_valid && out_ready.
- On accept: load out_addr, out_err and out_same; set out_valid=1; set prev_word=in_onehot and prev_vld=1.
- On drain without a simultaneous accept: out_valid=0. The other output fields keep their last value.
- Simultaneous drain and accept: the register reloads and out_valid stays 1.
- out_valid=1 with out_ready=0: all out_* fields stay stable until drained.
- Encoding:
  - Exactly one bit set at position k: out_addr=k, out_err=0.
  - Zero bits set: out_addr=0, out_err=1.
  - Two or more bits set: out_addr = index of the lowest set bit, out_err=1.
- out_same = prev_vld && (in_onehot == prev_word), evaluated at accept time. Data is still passed through when out_same is set.
- err_count increments by 1 on each accept with out_err=1 and saturates at all-ones.
- err_sticky is set on each accept with out_err=1.
- clear_err:
  - clear_err alone: err_count=0, err_sticky=0 on the next edge.
  - clear_err in the same cycle as an erroring accept: err_count=1, err_sticky=1 (the new error wins over the clear).
- in_onehot is sampled only on accept. Values while in_valid=0 or in_ready=0 have no effect.
- Reset asserted mid-operation: the held word is discarded and the block returns to the reset state immediately, without waiting for a clock edge.

Decomposition:
- Shared package onehot_pkg holds:
  - the default constants WIDTH=8, AW=3;
  - a function is_onehot(word) returning 1 when exactly one bit is set;
  - a function lsb_index(word) returning the lowest set index, or 0 when no bit is set.
- One combinational sub-module, onehot_encode, takes in_onehot and produces idx[AW-1:0] and err.
- The top level holds the output register, the prev_word compare, and the error counter.

Test Plan:
- Sweep, out_ready=1: in_onehot=00000001, 00000010, …, 10000000 on consecutive cycles -> out_addr=0…7 one cycle later each, out_err=0, out_same=0, in_ready=1 throughout.
- Missing-branch repeat: send 00100000 (address 5) then 00100000 again (address 6 decoding stale) -> second output has out_addr=5, out_same=1, out_err=0.
- Illegal words:
  - 00000000 -> out_addr=0, out_err=1.
  - 01001000 -> out_addr=3, out_err=1.
  - After both: err_count=2, err_sticky=1.
- Backpressure: fill the register, then hold out_ready=0 for 3 cycles while in_valid=1 with a new word -> in_ready=0, out_* unchanged. Release -> old word drains and the new word loads on the same edge.
- Saturation with CNT_W=2: five illegal words -> err_count=3. Then clear_err concurrent with a sixth illegal word -> err_count=1, err_sticky=1.
- Reset mid-operation: assert reset asynchronously between edges while out_valid=1, err_count=2 -> all outputs 0 immediately. After release, the first word has out_same=0.

Source files
------------

// File: rtl/onehot_pkg.sv
// Shared constants and one-hot helpers for the decoder capture stage.
// Helpers take a max-width word so any legal WIDTH can zero-extend into them.
package onehot_pkg;

  localparam int WIDTH = 8;
  localparam int AW    = 3;
  localparam int MAXW  = 256;

  function automatic logic is_onehot(input logic [MAXW-1:0] w);
    return (w != '0) && ((w & (w - MAXW'(1))) == '0);
  endfunction

  function automatic logic [7:0] lsb_index(input logic [MAXW-1:0] w);
    logic [7:0] idx;
    idx = '0;
    for (int i = MAXW - 1; i >= 0; i--) begin
      if (w[i]) idx = 8'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/onehot_capture_enc_encode.sv
// Combinational one-hot to index encoder with legality flag.
// Illegal words still report the lowest set bit so debug sees a hint.
module onehot_encode
  import onehot_pkg::*;
#(
  parameter int WIDTH = onehot_pkg::WIDTH,
  parameter int AW    = onehot_pkg::AW
) (
  input  logic [WIDTH-1:0] i_onehot,
  output logic [AW-1:0]    o_idx,
  output logic             o_err
);

  logic [MAXW-1:0] w_ext;

  always_comb begin
    w_ext = '0;
    w_ext[WIDTH-1:0] = i_onehot;
  end

  assign o_idx = AW'(lsb_index(w_ext));
  assign o_err = !is_onehot(w_ext);

endmodule

// File: rtl/onehot_capture_enc.sv
// Registered capture of the decoder one-hot word, re-encoded to an index,
// with legality check, stale-repeat flag and saturating error counter.
module onehot_capture_enc
  import onehot_pkg::*;
#(
  parameter int WIDTH = onehot_pkg::WIDTH,
  parameter int AW    = onehot_pkg::AW,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_onehot,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW-1:0]    out_addr,
  output logic             out_err,
  output logic             out_same,
  input  logic             clear_err,
  output logic [CNT_W-1:0] err_count,
  output logic             err_sticky
);

  if (WIDTH < 2 || WIDTH > 256 || (WIDTH & (WIDTH - 1)) != 0
      || AW != $clog2(WIDTH)) begin : g_bad_param
    $error("onehot_capture_enc: illegal WIDTH/AW");
  end

  logic             w_accept;
  logic             w_drain;
  logic             w_err;
  logic             w_same;
  logic [AW-1:0]    w_idx;
  logic [WIDTH-1:0] r_prev_word;
  logic             r_prev_vld;

  onehot_encode #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_enc (
    .i_onehot (in_onehot),
    .o_idx    (w_idx),
    .o_err    (w_err)
  );

  assign in_ready = !out_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_drain  = out_valid && out_ready;
  assign w_same   = r_prev_vld && (in_onehot == r_prev_word);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_addr    <= '0;
      out_err     <= 1'b0;
      out_same    <= 1'b0;
      r_prev_word <= '0;
      r_prev_vld  <= 1'b0;
    end else if (w_accept) begin
      out_valid   <= 1'b1;
      out_addr    <= w_idx;
      out_err     <= w_err;
      out_same    <= w_same;
      r_prev_word <= in_onehot;
      r_prev_vld  <= 1'b1;
    end else if (w_drain) begin
      out_valid   <= 1'b0;
    end
  end

  // A fresh error outranks a concurrent clear: it counts as the first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count  <= '0;
      err_sticky <= 1'b0;
    end else if (w_accept && w_err) begin
      err_sticky <= 1'b1;
      if (clear_err)
        err_count <= CNT_W'(1);
      else if (err_count != '1)
        err_count <= err_count + CNT_W'(1);
    end else if (clear_err) begin
      err_count  <= '0;
      err_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_onehot_capture_enc.sv
// Directed self-checking bench for onehot_capture_enc.
// Counter is built 2 bits wide so saturation is reachable quickly.
module tb_onehot_capture_enc;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_onehot;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_addr;
  logic       out_err;
  logic       out_same;
  logic       clear_err;
  logic [1:0] err_count;
  logic       err_sticky;

  int n_vec = 0;
  int n_err = 0;

  onehot_capture_enc #(
    .WIDTH (8),
    .AW    (3),
    .CNT_W (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_onehot  (in_onehot),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_err    (out_err),
    .out_same   (out_same),
    .clear_err  (clear_err),
    .err_count  (err_count),
    .err_sticky (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_onehot = '0;
    out_ready = 1'b1; clear_err = 1'b0;
    #12;
    n_vec++;
    if ({out_valid, out_addr, out_err, out_same} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_out: got v%b a%0d e%b s%b want all 0",
               out_valid, out_addr, out_err, out_same);
    end
    n_vec++;
    if ({err_count, err_sticky} !== 3'b0) begin
      n_err++;
      $display("FAIL reset_err: got cnt %0d sticky %b want 0 0",
               err_count, err_sticky);
    end
    @(negedge clk);
    reset = 1'b0;
    step();
  endtask

  task automatic test_sweep();
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_onehot = 8'(1 << i);
      n_vec++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL sweep_ready[%0d]: got %b want 1", i, in_ready);
      end
      step();
      n_vec++;
      if ({out_valid, out_addr, out_err, out_same} !== {1'b1, 3'(i), 2'b00}) begin
        n_err++;
        $display("FAIL sweep[%0d]: got v%b a%0d e%b s%b want v1 a%0d e0 s0",
                 i, out_valid, out_addr, out_err, out_same, i);
      end
    end
    in_valid = 1'b0;
    step();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL sweep_drain: got out_valid %b want 0", out_valid);
    end
  endtask

  task automatic test_repeat();
    in_valid = 1'b1;
    in_onehot = 8'b0010_0000;
    step();
    n_vec++;
    if ({out_addr, out_err, out_same} !== {3'd5, 2'b00}) begin
      n_err++;
      $display("FAIL repeat_first: got a%0d e%b s%b want a5 e0 s0",
               out_addr, out_err, out_same);
    end
    step();
    n_vec++;
    if ({out_valid, out_addr, out_err, out_same} !== {1'b1, 3'd5, 2'b01}) begin
      n_err++;
      $display("FAIL repeat_stale: got v%b a%0d e%b s%b want v1 a5 e0 s1",
               out_valid, out_addr, out_err, out_same);
    end
  endtask

  task automatic test_illegal();
    in_valid = 1'b1;
    in_onehot = 8'b0000_0000;
    step();
    n_vec++;
    if ({out_addr, out_err, out_same} !== {3'd0, 2'b10}) begin
      n_err++;
      $display("FAIL illegal_zero: got a%0d e%b s%b want a0 e1 s0",
               out_addr, out_err, out_same);
    end
    in_onehot = 8'b0100_1000;
    step();
    n_vec++;
    if ({out_addr, out_err} !== {3'd3, 1'b1}) begin
      n_err++;
      $display("FAIL illegal_multi: got a%0d e%b want a3 e1",
               out_addr, out_err);
    end
    in_valid = 1'b0;
    step();
    n_vec++;
    if ({err_count, err_sticky} !== {2'd2, 1'b1}) begin
      n_err++;
      $display("FAIL illegal_count: got cnt %0d sticky %b want 2 1",
               err_count, err_sticky);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_onehot = 8'b0000_0100;
    step();
    in_onehot = 8'b0001_0000;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_ready[%0d]: got %b want 0", i, in_ready);
      end
      step();
      n_vec++;
      if ({out_valid, out_addr, out_err, out_same} !== {1'b1, 3'd2, 2'b00}) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got v%b a%0d e%b s%b want v1 a2 e0 s0",
                 i, out_valid, out_addr, out_err, out_same);
      end
    end
    out_ready = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release_ready: got %b want 1", in_ready);
    end
    step();
    n_vec++;
    if ({out_valid, out_addr} !== {1'b1, 3'd4}) begin
      n_err++;
      $display("FAIL bp_reload: got v%b a%0d want v1 a4", out_valid, out_addr);
    end
    in_valid = 1'b0;
    step();
    n_vec++;
    if ({out_valid, out_addr} !== {1'b0, 3'd4}) begin
      n_err++;
      $display("FAIL bp_drain: got v%b a%0d want v0 a4", out_valid, out_addr);
    end
  endtask

  task automatic test_saturation();
    logic [7:0] bad [5];
    bad[0] = 8'h00; bad[1] = 8'h03; bad[2] = 8'h00;
    bad[3] = 8'h03; bad[4] = 8'hFF;
    in_valid = 1'b0;
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    n_vec++;
    if ({err_count, err_sticky} !== 3'b0) begin
      n_err++;
      $display("FAIL clear_alone: got cnt %0d sticky %b want 0 0",
               err_count, err_sticky);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_onehot = bad[i];
      step();
    end
    n_vec++;
    if ({err_count, err_sticky} !== {2'd3, 1'b1}) begin
      n_err++;
      $display("FAIL saturate: got cnt %0d sticky %b want 3 1",
               err_count, err_sticky);
    end
    clear_err = 1'b1;
    in_onehot = 8'h81;
    step();
    clear_err = 1'b0;
    in_valid = 1'b0;
    n_vec++;
    if ({err_count, err_sticky, out_err, out_addr} !== {2'd1, 1'b1, 1'b1, 3'd0}) begin
      n_err++;
      $display("FAIL clear_vs_err: got cnt %0d sticky %b e%b a%0d want 1 1 e1 a0",
               err_count, err_sticky, out_err, out_addr);
    end
    step();
  endtask

  task automatic test_reset_mid();
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_onehot = 8'h00;
    step();
    in_onehot = 8'hFF;
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    step();
    n_vec++;
    if ({out_valid, err_count} !== {1'b1, 2'd2}) begin
      n_err++;
      $display("FAIL mid_setup: got v%b cnt %0d want v1 cnt 2",
               out_valid, err_count);
    end
    #3;
    reset = 1'b1;
    #1;
    n_vec++;
    if ({out_valid, out_addr, out_err, out_same, err_count, err_sticky} !== 9'b0) begin
      n_err++;
      $display("FAIL mid_reset: got v%b a%0d e%b s%b cnt %0d sticky %b want all 0",
               out_valid, out_addr, out_err, out_same, err_count, err_sticky);
    end
    reset = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_onehot = 8'hFF;
    step();
    in_valid = 1'b0;
    n_vec++;
    if ({out_valid, out_same, out_err, err_count} !== {1'b1, 1'b0, 1'b1, 2'd1}) begin
      n_err++;
      $display("FAIL mid_after: got v%b s%b e%b cnt %0d want v1 s0 e1 cnt 1",
               out_valid, out_same, out_err, err_count);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_repeat();
    test_illegal();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
